// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default stage widths and the packed payloads
// carried between IF/ID/EX/MEM/WB by pipe_stage instances.
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CNT_W  = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

endpackage

// File: rtl/pipe_stall_cnt.sv
// Saturating stall counter with synchronous clear; clear beats increment.
module pipe_stall_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && cnt != {CNT_W{1'b1}})
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with flush and stall counting.
// Define PIPE_STAGE_SKID_EN for a two-entry skid version with registered in_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic accept;
    logic pop;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    // Registered ready: the skid entry absorbs the one payload that can arrive
    // in the cycle downstream stops.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || pop) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept)
                    out_data <= in_data;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`endif

    pipe_stall_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .clr (stall_clr),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: a default instance and a CNT_W=3 instance share stimulus
// and are checked against a queue-based model of the stage.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, stall_clr;
    logic [31:0] in_data;
    logic        in_ready, out_valid, in_ready3, out_valid3;
    logic [31:0] out_data, out_data3;
    logic [15:0] stall_cnt;
    logic [2:0]  stall_cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0] q[$];
    int        c16, c3;

    always #5 clk = ~clk;

    pipe_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    pipe_stage #(.DATA_W(32), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .stall_cnt(stall_cnt3), .stall_clr(stall_clr)
    );

    function automatic bit m_in_ready();
        if (CAP == 2) return q.size() < 2;
        return q.size() == 0 || out_ready;
    endfunction

    // Advance clock and model by one rising edge; leaves time at the next negedge.
    task automatic edge_step();
        bit mv  = q.size() > 0;
        bit mir = m_in_ready();
        @(posedge clk);
        if (rst) begin
            q.delete();
            c16 = 0;
            c3  = 0;
        end else begin
            if (stall_clr) begin
                c16 = 0;
                c3  = 0;
            end else if (mv && !out_ready) begin
                if (c16 < 65535) c16++;
                if (c3 < 7) c3++;
            end
            if (flush) q.delete();
            else begin
                if (mv && out_ready) void'(q.pop_front());
                if (in_valid && mir) q.push_back(in_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; stall_clr = 0; in_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            #1;
            n_tests++;
            if (out_valid !== 1'b0 || out_valid3 !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid: got %b/%b want 0", out_valid, out_valid3);
            end
            n_tests++;
            if (out_data !== 32'h0 || out_data3 !== 32'h0) begin
                n_fail++; $display("FAIL reset_out_data: got %h/%h want 0", out_data, out_data3);
            end
            n_tests++;
            if (stall_cnt !== 16'd0 || stall_cnt3 !== 3'd0) begin
                n_fail++; $display("FAIL reset_stall_cnt: got %0d/%0d want 0", stall_cnt, stall_cnt3);
            end
        end
        rst = 0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b/%b want 1", in_ready, in_ready3);
        end
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1; in_data = 32'(k);
            edge_step();
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 32'(k)) begin
                n_fail++; $display("FAIL stream_%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, k);
            end
        end
        in_valid = 0;
        edge_step();
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL stream_drain: got v=%b cnt=%0d want v=0 cnt=0", out_valid, stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit exp_ir;
        in_valid = 1; in_data = 32'hDEADBEEF; out_ready = 1;
        edge_step();
        out_ready = 0; in_data = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_ir = (CAP == 2) && (i == 0);
            n_tests++;
            if (in_ready !== exp_ir) begin
                n_fail++; $display("FAIL bp_in_ready_%0d: got %b want %b", i, in_ready, exp_ir);
            end
            edge_step();
        end
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=deadbeef", out_valid, out_data);
        end
        n_tests++;
        if (stall_cnt !== 16'd4 || stall_cnt3 !== 3'd4) begin
            n_fail++; $display("FAIL bp_stall_cnt: got %0d/%0d want 4", stall_cnt, stall_cnt3);
        end
        in_valid = 0; out_ready = 1;
        edge_step();
        #1;
        n_tests++;
        if (out_valid !== (CAP == 2)) begin
            n_fail++; $display("FAIL bp_release_valid: got %b want %b", out_valid, CAP == 2);
        end
        if (q.size() > 0) begin
            n_tests++;
            if (out_data !== 32'hCAFEF00D) begin
                n_fail++; $display("FAIL bp_order: got %h want cafef00d", out_data);
            end
        end
        edge_step();
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        in_valid = 1; in_data = 32'h11; out_ready = 0;
        edge_step();
        in_data = 32'h22; flush = 1;
        edge_step();
        flush = 0; in_valid = 0; out_ready = 1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_valid3 !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid: got %b/%b want 0", out_valid, out_valid3);
        end
        for (int i = 0; i < 3; i++) begin
            edge_step();
            #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_no_22_%0d: got v=%b d=%h want v=0", i, out_valid, out_data);
            end
        end
        n_tests++;
        if (stall_cnt !== 16'(c16)) begin
            n_fail++; $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, c16);
        end
    endtask

    task automatic test_saturation();
        in_valid = 1; in_data = 32'h55; out_ready = 0; stall_clr = 1;
        edge_step();
        in_valid = 0; stall_clr = 0;
        for (int i = 0; i < 10; i++) edge_step();
        #1;
        n_tests++;
        if (stall_cnt3 !== 3'd7 || stall_cnt !== 16'd10) begin
            n_fail++; $display("FAIL sat_cnt: got %0d/%0d want 7/10", stall_cnt3, stall_cnt);
        end
        n_tests++;
        if (out_data !== 32'h55) begin
            n_fail++; $display("FAIL sat_hold: got %h want 00000055", out_data);
        end
        stall_clr = 1;
        edge_step();
        #1;
        n_tests++;
        if (stall_cnt3 !== 3'd0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL sat_clr: got %0d/%0d want 0", stall_cnt3, stall_cnt);
        end
        stall_clr = 0;
        edge_step();
        #1;
        n_tests++;
        if (stall_cnt3 !== 3'd1 || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL sat_after_clr: got %0d/%0d want 1", stall_cnt3, stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1; in_data = 32'h66; out_ready = 0;
        edge_step();
        rst = 1; in_valid = 0;
        edge_step();
        rst = 0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid: got v=%b cnt=%0d rdy=%b want 0/0/1", out_valid, stall_cnt, in_ready);
        end
        n_tests++;
        if (out_valid3 !== 1'b0 || stall_cnt3 !== 3'd0 || in_ready3 !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid3: got v=%b cnt=%0d rdy=%b want 0/0/1", out_valid3, stall_cnt3, in_ready3);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 4);
            stall_clr = ($urandom_range(0, 99) < 4);
            rst       = ($urandom_range(0, 99) < 2);
            #1;
            n_tests++;
            if (in_ready !== m_in_ready() || in_ready3 !== m_in_ready()) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rnd_in_ready@%0d: got %b/%b want %b", i, in_ready, in_ready3, m_in_ready());
            end
            n_tests++;
            if (out_valid !== (q.size() > 0)) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rnd_out_valid@%0d: got %b want %b", i, out_valid, q.size() > 0);
            end
            if (q.size() > 0) begin
                n_tests++;
                if (out_data !== q[0] || out_data3 !== q[0]) begin
                    n_fail++; errs++;
                    if (errs < 10) $display("FAIL rnd_out_data@%0d: got %h/%h want %h", i, out_data, out_data3, q[0]);
                end
            end
            n_tests++;
            if (stall_cnt !== 16'(c16) || stall_cnt3 !== 3'(c3)) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rnd_stall_cnt@%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, stall_cnt3, c16, c3);
            end
            edge_step();
        end
        rst = 0; flush = 0; stall_clr = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
